tone_decoder: RTL and testbench
===============================

TONE_DECODER -- requirements
Module: tone_decoder

Interface
REQ-001 Parameter WINDOW, default 5_000_000, gate window length in clk cycles (100 ms at 50 MHz).
REQ-002 Parameter CONFIRM, default 3, consecutive same-class windows required before a decision.
REQ-003 Parameters FWD_LO/FWD_HI, default 90/110, edge-count band for TD_FORWARD (1 kHz).
REQ-004 Parameters LFT_LO/LFT_HI, default 180/220, band for TD_LEFT (2 kHz).
REQ-005 Parameters RGT_LO/RGT_HI, default 270/330, band for TD_RIGHT (3 kHz).
REQ-006 Parameters REV_LO/REV_HI, default 360/440, band for TD_REVERSE (4 kHz).
REQ-007 Parameters STP_LO/STP_HI, default 450/550, band for TD_STOP (5 kHz).
REQ-008 Codes: TD_HOLD=0, TD_FORWARD=1, TD_LEFT=2, TD_RIGHT=3, TD_REVERSE=4, TD_STOP=5.
REQ-009 clk  input  1  single system clock, all logic on rising edge.
REQ-010 rst  input  1  asynchronous, active-high reset.
REQ-011 enableToneDetection  input  1  request from drive controller; high = measure and decide.
REQ-012 toneIn  input  1  asynchronous digital tone from mic comparator.
REQ-013 toneDir  output  3  decided direction code; TD_HOLD while undecided.
REQ-014 measuring  output  1  high while in MEASURE state.
REQ-015 lastCount  output  16  rising-edge count of the most recently closed window.

Function
REQ-016 toneIn SHALL pass through a 2-flop synchronizer; a rising edge is sync=1 and previous sync=0.
REQ-017 States: IDLE, MEASURE, DECIDED.
REQ-018 IDLE: toneDir=TD_HOLD, window/edge/confirm counters held at 0; enable=1 -> MEASURE next cycle.
REQ-019 MEASURE: window counter increments each cycle; edge counter increments per rising edge, saturating at 65535.
REQ-020 Window close occurs on the cycle the window counter equals WINDOW-1; an edge on that cycle counts in the closing window.
REQ-021 At close: lastCount <= final count; edge and window counters restart at 0 the next cycle with no gap.
REQ-022 Classification: count within [LO,HI] inclusive of a band gives that class; any other count gives NONE.
REQ-023 Confirm: class equal to previous window's non-NONE class -> confirm+1; different class -> confirm=1 with new class; NONE -> confirm=0.
REQ-024 When confirm reaches CONFIRM at a close, toneDir SHALL take that code the next cycle and state -> DECIDED.
REQ-025 Minimum latency, enable rise to toneDir valid: 1 + CONFIRM*WINDOW cycles.
REQ-026 DECIDED: toneDir held constant, no measurement, until enable=0.
REQ-027 enable=0 in any state -> IDLE next cycle, toneDir=TD_HOLD, all counters cleared, partial window discarded.
REQ-028 enable low for a single cycle SHALL still abort and restart a full measurement.
REQ-029 measuring SHALL be high exactly while state is MEASURE.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, toneDir=TD_HOLD, measuring=0, lastCount=0, and all counters and synchronizer flops to 0.
REQ-031 rst asserted mid-window or in DECIDED SHALL discard all progress; after release, a new decision requires CONFIRM full windows.

Verification (bench overrides WINDOW=1000, CONFIRM=3; default bands)
REQ-032 enable=1, toneIn period 10 cycles -> lastCount=100 each window; toneDir=TD_FORWARD exactly 3001 cycles after enable rise.
REQ-033 enable=1, period 5 for 2 windows, then period 10 -> no decision after window 3; TD_FORWARD after window 5.
REQ-034 enable=1, period 4 (count 250, band gap) -> toneDir stays TD_HOLD indefinitely; measuring stays 1.
REQ-035 TD_LEFT decided, enable dropped 1 cycle then re-raised -> toneDir=TD_HOLD next cycle; new decision after 3 more windows.
REQ-036 rst pulse mid window 2 of period-10 tone -> all outputs 0; TD_FORWARD 3001 cycles after rst release with enable held.
REQ-037 enable=1, toneIn constant high -> lastCount=0 (count reflects at most one edge at start), toneDir=TD_HOLD.

Source files
------------

// File: rtl/tone_decoder.sv
// rtl/tone_decoder.sv - classifies a digital tone by rising-edge count per gate window
// Direction is committed only after CONFIRM consecutive windows agree on the same band.
module tone_decoder #(
  parameter int WINDOW  = 5_000_000,
  parameter int CONFIRM = 3,
  parameter int FWD_LO  = 90,
  parameter int FWD_HI  = 110,
  parameter int LFT_LO  = 180,
  parameter int LFT_HI  = 220,
  parameter int RGT_LO  = 270,
  parameter int RGT_HI  = 330,
  parameter int REV_LO  = 360,
  parameter int REV_HI  = 440,
  parameter int STP_LO  = 450,
  parameter int STP_HI  = 550
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enableToneDetection,
  input  logic        toneIn,
  output logic [2:0]  toneDir,
  output logic        measuring,
  output logic [15:0] lastCount
);

  localparam logic [2:0] TD_HOLD    = 3'd0;
  localparam logic [2:0] TD_FORWARD = 3'd1;
  localparam logic [2:0] TD_LEFT    = 3'd2;
  localparam logic [2:0] TD_RIGHT   = 3'd3;
  localparam logic [2:0] TD_REVERSE = 3'd4;
  localparam logic [2:0] TD_STOP    = 3'd5;

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int CW = $clog2(CONFIRM + 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW - 1);
  localparam logic [CW-1:0] CONF_TARGET = CW'(CONFIRM);

  typedef enum logic [1:0] {IDLE, MEASURE, DECIDED} state_t;

  state_t        state, stateNext;
  logic          sync1, sync2, syncPrev;
  logic          risingEdge;
  logic [WW-1:0] winCnt;
  logic [15:0]   edgeCnt;
  logic [15:0]   closeCount;
  logic [CW-1:0] confirm;
  logic [CW-1:0] nextConfirm;
  logic [2:0]    prevClass;
  logic [2:0]    cls;
  logic          windowClose;
  logic          decide;

  // TD_HOLD doubles as the "no band matched" class.
  function automatic logic [2:0] classify(input logic [15:0] c);
    int v;
    v = int'(c);
    if (v >= FWD_LO && v <= FWD_HI)      return TD_FORWARD;
    else if (v >= LFT_LO && v <= LFT_HI) return TD_LEFT;
    else if (v >= RGT_LO && v <= RGT_HI) return TD_RIGHT;
    else if (v >= REV_LO && v <= REV_HI) return TD_REVERSE;
    else if (v >= STP_LO && v <= STP_HI) return TD_STOP;
    else                                 return TD_HOLD;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      syncPrev <= 1'b0;
    end else begin
      sync1    <= toneIn;
      sync2    <= sync1;
      syncPrev <= sync2;
    end
  end

  assign risingEdge  = sync2 & ~syncPrev;
  assign windowClose = (state == MEASURE) && enableToneDetection && (winCnt == WIN_LAST);
  // An edge landing on the closing cycle still belongs to the closing window.
  assign closeCount  = (risingEdge && edgeCnt != 16'hFFFF) ? edgeCnt + 16'd1 : edgeCnt;
  assign cls         = classify(closeCount);

  always_comb begin
    nextConfirm = '0;
    if (cls == TD_HOLD)
      nextConfirm = '0;
    else if (cls == prevClass)
      nextConfirm = confirm + 1'b1;
    else
      nextConfirm = CW'(1);
  end

  assign decide    = windowClose && (nextConfirm == CONF_TARGET);
  assign measuring = (state == MEASURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (enableToneDetection) stateNext = MEASURE;
      MEASURE: begin
        if (!enableToneDetection) stateNext = IDLE;
        else if (decide)          stateNext = DECIDED;
      end
      DECIDED: if (!enableToneDetection) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winCnt    <= '0;
      edgeCnt   <= '0;
      confirm   <= '0;
      prevClass <= TD_HOLD;
      lastCount <= '0;
    end else if (state != MEASURE || !enableToneDetection) begin
      winCnt    <= '0;
      edgeCnt   <= '0;
      confirm   <= '0;
      prevClass <= TD_HOLD;
    end else if (windowClose) begin
      winCnt    <= '0;
      edgeCnt   <= '0;
      confirm   <= nextConfirm;
      prevClass <= cls;
      lastCount <= closeCount;
    end else begin
      winCnt <= winCnt + 1'b1;
      if (risingEdge && edgeCnt != 16'hFFFF)
        edgeCnt <= edgeCnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       toneDir <= TD_HOLD;
    else if (!enableToneDetection) toneDir <= TD_HOLD;
    else if (decide)               toneDir <= cls;
  end

endmodule

// File: tb/tb_tone_decoder.sv
// tb/tb_tone_decoder.sv - directed scoreboard bench for tone_decoder
// Tone periods are exact cycle multiples, so per-window edge counts are exact.
module tb_tone_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enableToneDetection = 1'b0;
  logic        toneIn = 1'b0;
  logic [2:0]  toneDir;
  logic        measuring;
  logic [15:0] lastCount;

  tone_decoder #(.WINDOW(1000), .CONFIRM(3)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .enableToneDetection (enableToneDetection),
    .toneIn              (toneIn),
    .toneDir             (toneDir),
    .measuring           (measuring),
    .lastCount           (lastCount)
  );

  always #5 clk = ~clk;

  int tonePeriod = 10;
  bit toneConst  = 1'b0;
  int phase      = 0;

  always @(negedge clk) begin
    if (toneConst) toneIn = 1'b1;
    else begin
      phase  = (phase + 1 >= tonePeriod) ? 0 : phase + 1;
      toneIn = (phase < tonePeriod / 2);
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      failed++;
      $error("FAIL scoreboard_empty observed=%0d", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failed++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // reset state
    push("rst_dir", 0); push("rst_meas", 0); push("rst_last", 0);
    cyc(3);
    check(32'(toneDir)); check(32'(measuring)); check(32'(lastCount));
    rst = 1'b0;
    cyc(2);

    // period 10 -> forward exactly 3001 cycles after enable rise
    push("fwd_meas", 1); push("fwd_last", 100); push("fwd_hold_3000", 0);
    push("fwd_dir_3001", 1); push("fwd_decided_meas", 0); push("fwd_held", 1);
    enableToneDetection = 1'b1;
    cyc(1);    check(32'(measuring));
    cyc(1499); check(32'(lastCount));
    cyc(1500); check(32'(toneDir));
    cyc(1);    check(32'(toneDir)); check(32'(measuring));
    cyc(500);  check(32'(toneDir));

    // single-cycle abort, then period 5 -> left
    tonePeriod = 5;
    push("left_abort_hold", 0); push("left_hold_3000", 0); push("left_dir_3001", 2);
    enableToneDetection = 1'b0;
    cyc(1);    check(32'(toneDir));
    enableToneDetection = 1'b1;
    cyc(3000); check(32'(toneDir));
    cyc(1);    check(32'(toneDir));

    // from LEFT decided, 1-cycle drop restarts a full measurement
    push("relaunch_hold", 0); push("relaunch_last", 200);
    push("relaunch_hold_3000", 0); push("relaunch_dir_3001", 2);
    enableToneDetection = 1'b0;
    cyc(1);    check(32'(toneDir));
    enableToneDetection = 1'b1;
    cyc(1500); check(32'(lastCount));
    cyc(1500); check(32'(toneDir));
    cyc(1);    check(32'(toneDir));

    // two left windows then forward: class change resets confirmation
    push("switch_w3_hold", 0); push("switch_w3_meas", 1);
    push("switch_hold_5000", 0); push("switch_fwd_5001", 1);
    enableToneDetection = 1'b0;
    tonePeriod = 5;
    cyc(5);
    enableToneDetection = 1'b1;
    cyc(1998);
    tonePeriod = 10;
    cyc(1003); check(32'(toneDir)); check(32'(measuring));
    cyc(1999); check(32'(toneDir));
    cyc(1);    check(32'(toneDir));

    // period 4 -> count 250 in band gap, never decides
    push("gap_dir", 0); push("gap_meas", 1); push("gap_last", 250);
    enableToneDetection = 1'b0;
    tonePeriod = 4;
    cyc(5);
    enableToneDetection = 1'b1;
    cyc(4000); check(32'(toneDir)); check(32'(measuring)); check(32'(lastCount));

    // reset mid window 2 discards progress
    push("midrst_dir", 0); push("midrst_meas", 0); push("midrst_last", 0);
    push("midrst_hold_3000", 0); push("midrst_fwd_3001", 1);
    enableToneDetection = 1'b0;
    tonePeriod = 10;
    cyc(5);
    enableToneDetection = 1'b1;
    cyc(1500);
    rst = 1'b1;
    #1;
    check(32'(toneDir)); check(32'(measuring)); check(32'(lastCount));
    cyc(3);
    rst = 1'b0;
    cyc(3000); check(32'(toneDir));
    cyc(1);    check(32'(toneDir));

    // constant high tone -> no edges, no decision
    push("const_last", 0); push("const_dir", 0); push("const_meas", 1);
    enableToneDetection = 1'b0;
    toneConst = 1'b1;
    cyc(5);
    enableToneDetection = 1'b1;
    cyc(2500); check(32'(lastCount));
    cyc(1000); check(32'(toneDir)); check(32'(measuring));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
